// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Detects rising and falling edges on N level inputs that are already
//   synchronous to clk. Each channel holds at most one pending event.
//   Pending events are serialised onto one valid/ready event port by a
//   round-robin arbiter.
//
// Ports
//   clk       in   single clock, posedge
//   reset     in   synchronous, active-high
//   level     in   [N-1:0]   per-channel level
//   ev_ready  in   consumer accepts on ev_valid && ev_ready
//   clr_ovf   in   one-cycle pulse, clears overflow bits not being set
//   ev_valid  out  event present (registered)
//   ev_ch     out  [IDW-1:0] channel of the presented event (registered)
//   ev_rise   out  1 = rising edge, 0 = falling edge (registered)
//   overflow  out  [N-1:0]   sticky per-channel lost-edge flag
module edge_event_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   level,
    input  logic           ev_ready,
    input  logic           clr_ovf,
    output logic           ev_valid,
    output logic [IDW-1:0] ev_ch,
    output logic           ev_rise,
    output logic [N-1:0]   overflow
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t         state_q,   state_d;
    logic [N-1:0]   level_q,   level_d;
    logic [N-1:0]   pend_q,    pend_d;
    logic [N-1:0]   pol_q,     pol_d;
    logic [N-1:0]   ovf_q,     ovf_d;
    logic [IDW-1:0] ptr_q,     ptr_d;
    logic [IDW-1:0] ev_ch_q,   ev_ch_d;
    logic           ev_rise_q, ev_rise_d;

    logic [N-1:0]   edge_det;
    logic [N-1:0]   pop;
    logic [N-1:0]   ovf_set;
    logic           any_pend;
    logic           found;
    logic [IDW-1:0] grant_idx;
    logic           do_grant;

    assign edge_det = level ^ level_q;
    assign any_pend = |pend_q;

    // Round-robin search: first set pend bit starting at ptr, wrapping.
    always_comb begin
        logic [IDW-1:0] idx;
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDW'((32'(ptr_q) + k) % N);
            if (!found && pend_q[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Arbiter FSM: next state and output register loads.
    always_comb begin
        state_d   = state_q;
        ev_ch_d   = ev_ch_q;
        ev_rise_d = ev_rise_q;
        ptr_d     = ptr_q;
        do_grant  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_pend) begin
                    do_grant = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ev_ready) begin
                    if (any_pend) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_grant && found) begin
            ev_ch_d   = grant_idx;
            ev_rise_d = pol_q[grant_idx];
            ptr_d     = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    // Pending slots and overflow. A slot popped this cycle counts as free,
    // so an edge arriving on the grant cycle refills it without overflow.
    always_comb begin
        pop = '0;
        if (do_grant && found) begin
            pop[grant_idx] = 1'b1;
        end

        level_d = level;
        pend_d  = pend_q & ~pop;
        pol_d   = pol_q;
        ovf_set = '0;

        for (int unsigned i = 0; i < N; i++) begin
            if (edge_det[i]) begin
                pend_d[i]  = 1'b1;
                pol_d[i]   = level[i];
                ovf_set[i] = pend_q[i] & ~pop[i];
            end
        end

        // Set wins over clear for the same bit.
        ovf_d = ovf_set | (clr_ovf ? '0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            level_q   <= level;
            pend_q    <= '0;
            pol_q     <= '0;
            ovf_q     <= '0;
            ptr_q     <= '0;
            ev_ch_q   <= '0;
            ev_rise_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            pend_q    <= pend_d;
            pol_q     <= pol_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
            ev_ch_q   <= ev_ch_d;
            ev_rise_q <= ev_rise_d;
        end
    end

    assign ev_valid = (state_q == ST_HOLD);
    assign ev_ch    = ev_ch_q;
    assign ev_rise  = ev_rise_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter
//   Directed test of edge_event_arbiter (N=4, IDW=2). Inputs change 1ns
//   after each posedge and outputs are sampled at the same point, so each
//   tick() advances exactly one clock edge.
module tb_edge_event_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] level;
    logic       ev_ready;
    logic       clr_ovf;
    logic       ev_valid;
    logic [1:0] ev_ch;
    logic       ev_rise;
    logic [3:0] overflow;

    int n_checks = 0;
    int n_fail   = 0;

    edge_event_arbiter #(.N(4), .IDW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .level    (level),
        .ev_ready (ev_ready),
        .clr_ovf  (clr_ovf),
        .ev_valid (ev_valid),
        .ev_ch    (ev_ch),
        .ev_rise  (ev_rise),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input logic v, input logic [1:0] ch, input logic r);
        chk({tag, "_valid"}, 32'(ev_valid), 32'(v));
        if (v) begin
            chk({tag, "_ch"},   32'(ev_ch),   32'(ch));
            chk({tag, "_rise"}, 32'(ev_rise), 32'(r));
        end
    endtask

    initial begin
        // Reset with channel 0 high: no event may appear afterwards.
        reset    = 1'b1;
        level    = 4'b0001;
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_ch",    32'(ev_ch),    0);
        chk("rst_rise",  32'(ev_rise),  0);
        chk("rst_ovf",   32'(overflow), 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_after_rst", 32'(ev_valid), 0);
        end
        chk("idle_ovf", 32'(overflow), 0);

        // Bring channel 0 low first (one falling event), then the rise test.
        ev_ready = 1'b1;
        level    = 4'b0000;
        tick();
        chk_ev("pre_fall_lat", 1'b0, 2'd0, 1'b0);
        tick();
        chk_ev("pre_fall", 1'b1, 2'd0, 1'b0);
        tick();
        chk_ev("pre_fall_done", 1'b0, 2'd0, 1'b0);

        level = 4'b0001;
        tick();                                   // posedge k: pend set
        chk_ev("rise0_lat", 1'b0, 2'd0, 1'b0);
        tick();                                   // posedge k+1: presented
        chk_ev("rise0", 1'b1, 2'd0, 1'b1);
        tick();
        chk_ev("rise0_done", 1'b0, 2'd0, 1'b0);
        level = 4'b0000;
        tick();
        chk_ev("fall0_lat", 1'b0, 2'd0, 1'b0);
        tick();
        chk_ev("fall0", 1'b1, 2'd0, 1'b0);
        tick();
        chk_ev("fall0_done", 1'b0, 2'd0, 1'b0);

        // Reset to bring ptr back to 0, then all four channels rise together.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        level = 4'b1111;
        tick();
        chk_ev("all_lat", 1'b0, 2'd0, 1'b0);
        tick();
        chk_ev("all_ev0", 1'b1, 2'd0, 1'b1);
        tick();
        chk_ev("all_ev1", 1'b1, 2'd1, 1'b1);
        tick();
        chk_ev("all_ev2", 1'b1, 2'd2, 1'b1);
        tick();
        chk_ev("all_ev3", 1'b1, 2'd3, 1'b1);
        tick();
        chk_ev("all_done", 1'b0, 2'd0, 1'b0);
        chk("all_ovf", 32'(overflow), 0);

        // Channel 2 low first (consumed), leaving ptr = 3.
        level = 4'b1011;
        tick();
        tick();
        chk_ev("c2_fall", 1'b1, 2'd2, 1'b0);
        tick();
        chk_ev("c2_fall_done", 1'b0, 2'd0, 1'b0);

        // Channel 2: rise, fall, rise on consecutive cycles with ev_ready = 0.
        ev_ready = 1'b0;
        level    = 4'b1111;
        tick();                                   // rise pended
        level = 4'b1011;
        tick();                                   // granted; fall refills slot
        chk_ev("ovf_first", 1'b1, 2'd2, 1'b1);
        chk("ovf_none_yet", 32'(overflow), 32'h0);
        level = 4'b1111;
        tick();                                   // rise hits occupied slot
        chk_ev("ovf_held", 1'b1, 2'd2, 1'b1);
        chk("ovf_set", 32'(overflow), 32'h4);
        tick();
        chk_ev("ovf_held2", 1'b1, 2'd2, 1'b1);
        ev_ready = 1'b1;
        tick();                                   // handshake, newest pol = rise
        chk_ev("ovf_second", 1'b1, 2'd2, 1'b1);
        tick();
        chk_ev("ovf_idle", 1'b0, 2'd0, 1'b0);
        chk("ovf_sticky", 32'(overflow), 32'h4);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'h0);

        // Channels 1 and 3 alternately toggle, one edge per cycle.
        for (int i = 0; i < 6; i++) begin
            level[(i % 2 == 0) ? 1 : 3] = ~level[(i % 2 == 0) ? 1 : 3];
            tick();
            if (i > 0) begin
                chk("alt_valid", 32'(ev_valid), 1);
                chk("alt_ch",    32'(ev_ch),    (i % 2 == 1) ? 32'd1 : 32'd3);
            end
        end
        tick();
        chk_ev("alt_last", 1'b1, 2'd3, 1'b0);
        tick();
        chk_ev("alt_done", 1'b0, 2'd0, 1'b0);
        chk("alt_ovf", 32'(overflow), 0);

        // Reset mid-hold with several slots pending.
        ev_ready = 1'b0;
        level    = 4'b1010;                      // from 0101: all four edges
        tick();
        tick();
        chk_ev("mid_hold", 1'b1, 2'd0, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(ev_valid),   0);
        chk("mid_rst_pend",  32'(dut.pend_q), 0);
        chk("mid_rst_ch",    32'(ev_ch),      0);
        reset    = 1'b0;
        ev_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_idle", 32'(ev_valid), 0);
        end
        chk("post_rst_ovf", 32'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
